// File: rtl/clkdiv_ctrl.sv
// -----------------------------------------------------------------------------
// clkdiv_ctrl
// Configuration sequencer for an integer clock divider. Ratio/enable change
// requests arrive over a valid/ready handshake and are range-checked. An
// accepted request reaches the divider only right after a falling edge of the
// divided clock. The divider counter is then at 0 or 1 when the new ratio lands,
// so the change cannot glitch or overrun the counter. After an enabled change,
// lock is reported once the divided clock has produced LOCK_EDGES rising edges.
//
// Optional feature macro: CLKDIV_CTRL_PERIOD_CHK_EN
//   When defined, SETTLE also measures each divided-clock period (rise to rise)
//   and requires it to equal 2*O_div_ratio reference cycles. A mismatch pulses
//   O_err and restarts the edge count. Eight mismatches in a row give up and
//   return to IDLE unlocked.
//
// Ports:
//   I_ref_clk    in   reference clock (also clocks the divider)
//   I_rst_n      in   asynchronous active-low reset
//   I_req_valid  in   request present
//   O_req_ready  out  request can be accepted (IDLE only)
//   I_req_ratio  in   requested division ratio [DIV_W]
//   I_req_en     in   requested divider enable
//   I_div_clk    in   divided clock fed back from the divider
//   O_div_ratio  out  ratio to the divider [DIV_W]
//   O_clk_en     out  enable to the divider
//   O_busy       out  waiting for an edge or settling
//   O_locked     out  divider running at the last applied configuration
//   O_err        out  one-cycle pulse: request rejected / period error
//   O_timeout    out  one-cycle pulse: apply forced by timeout
// -----------------------------------------------------------------------------
module clkdiv_ctrl #(
  parameter int DIV_W       = 32,
  parameter int MAX_RATIO   = 1024,
  parameter int RESET_RATIO = 2,
  parameter int LOCK_EDGES  = 4,
  parameter int TIMEOUT_CYC = 2*MAX_RATIO+4
) (
  input  logic             I_ref_clk,
  input  logic             I_rst_n,
  input  logic             I_req_valid,
  output logic             O_req_ready,
  input  logic [DIV_W-1:0] I_req_ratio,
  input  logic             I_req_en,
  input  logic             I_div_clk,
  output logic [DIV_W-1:0] O_div_ratio,
  output logic             O_clk_en,
  output logic             O_busy,
  output logic             O_locked,
  output logic             O_err,
  output logic             O_timeout
);

  localparam int WAIT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int EDGE_W = (LOCK_EDGES > 1) ? $clog2(LOCK_EDGES + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(LOCK_EDGES - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_EDGE = 2'd1,
    ST_SETTLE    = 2'd2
  } state_t;

  state_t             state_r, state_s, stay_s;
  logic               div_d_r;
  logic               fall_s, rise_s, req_bad_s;
  logic [DIV_W-1:0]   cap_ratio_r, cap_ratio_s;
  logic               cap_en_r, cap_en_s;
  logic [DIV_W-1:0]   div_ratio_r, div_ratio_s;
  logic               clk_en_r, clk_en_s;
  logic               locked_r, locked_s;
  logic               err_r, err_s;
  logic               timeout_r, timeout_s;
  logic               ready_r, ready_s;
  logic               busy_r, busy_s;
  logic [WAIT_W-1:0]  wait_cnt_r, wait_cnt_s;
  logic [EDGE_W-1:0]  edge_cnt_r, edge_cnt_s, edge_cnt_c;
  logic               apply_s, apply_en_s;
  logic [DIV_W-1:0]   apply_ratio_s;

`ifdef CLKDIV_CTRL_PERIOD_CHK_EN
  localparam int PER_W = DIV_W + 2;
  logic [PER_W-1:0]   per_cnt_r, per_cnt_s, per_cnt_c;
  logic               per_on_r, per_on_s, per_on_c;
  logic [3:0]         miss_cnt_r, miss_cnt_s, miss_cnt_c;
`endif

  // Edge detection on the fed-back divided clock.
  assign fall_s = div_d_r & ~I_div_clk;
  assign rise_s = ~div_d_r & I_div_clk;

  // Ratio range check only matters when the request enables the divider.
  assign req_bad_s = I_req_en &&
                     ((I_req_ratio < DIV_W'(2)) || (I_req_ratio > DIV_W'(MAX_RATIO)));

  // Outputs are registered copies of the internal state.
  assign O_req_ready = ready_r;
  assign O_busy      = busy_r;
  assign O_div_ratio = div_ratio_r;
  assign O_clk_en    = clk_en_r;
  assign O_locked    = locked_r;
  assign O_err       = err_r;
  assign O_timeout   = timeout_r;

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    stay_s        = state_r;
    cap_ratio_s   = cap_ratio_r;
    cap_en_s      = cap_en_r;
    locked_s      = locked_r;
    err_s         = 1'b0;
    timeout_s     = 1'b0;
    wait_cnt_s    = wait_cnt_r;
    edge_cnt_c    = edge_cnt_r;
    apply_s       = 1'b0;
    apply_ratio_s = cap_ratio_r;
    apply_en_s    = cap_en_r;
`ifdef CLKDIV_CTRL_PERIOD_CHK_EN
    per_cnt_c     = per_cnt_r;
    per_on_c      = per_on_r;
    miss_cnt_c    = miss_cnt_r;
`endif

    case (state_r)
      ST_IDLE: begin
        if (I_req_valid && ready_r) begin
          if (req_bad_s) begin
            err_s = 1'b1;
          end else begin
            locked_s    = 1'b0;
            cap_ratio_s = I_req_ratio;
            cap_en_s    = I_req_en;
            if (clk_en_r) begin
              // Divider running: hold the change until a falling edge.
              stay_s     = ST_WAIT_EDGE;
              wait_cnt_s = '0;
            end else begin
              // Divider stopped: nothing to glitch, apply right away.
              apply_s       = 1'b1;
              apply_ratio_s = I_req_ratio;
              apply_en_s    = I_req_en;
            end
          end
        end else begin
          stay_s = ST_IDLE;
        end
      end

      ST_WAIT_EDGE: begin
        // A fall in this cycle means the divider counter is at 0 now and will
        // be at 1 when the registered ratio arrives.
        if (fall_s || (wait_cnt_r == WAIT_LAST)) begin
          apply_s   = 1'b1;
          timeout_s = ~fall_s;
        end else begin
          wait_cnt_s = wait_cnt_r + WAIT_W'(1);
        end
      end

      ST_SETTLE: begin
`ifdef CLKDIV_CTRL_PERIOD_CHK_EN
        if (rise_s) begin
          per_on_c  = 1'b1;
          per_cnt_c = PER_W'(1);
          // The first rise only opens the measurement window.
          if (per_on_r && (per_cnt_r != {1'b0, div_ratio_r, 1'b0})) begin
            err_s      = 1'b1;
            edge_cnt_c = '0;
            if (miss_cnt_r == 4'd7) begin
              stay_s     = ST_IDLE;
              locked_s   = 1'b0;
              miss_cnt_c = 4'd0;
            end else begin
              miss_cnt_c = miss_cnt_r + 4'd1;
            end
          end else begin
            miss_cnt_c = 4'd0;
            if (edge_cnt_r == EDGE_LAST) begin
              locked_s = 1'b1;
              stay_s   = ST_IDLE;
            end else begin
              edge_cnt_c = edge_cnt_r + EDGE_W'(1);
            end
          end
        end else begin
          // Saturate so a stalled divided clock cannot wrap into a false match.
          if (per_cnt_r != {PER_W{1'b1}}) begin
            per_cnt_c = per_cnt_r + PER_W'(1);
          end else begin
            per_cnt_c = per_cnt_r;
          end
        end
`else
        if (rise_s) begin
          if (edge_cnt_r == EDGE_LAST) begin
            locked_s = 1'b1;
            stay_s   = ST_IDLE;
          end else begin
            edge_cnt_c = edge_cnt_r + EDGE_W'(1);
          end
        end else begin
          edge_cnt_c = edge_cnt_r;
        end
`endif
      end

      default: begin
        stay_s = ST_IDLE;
      end
    endcase

    // Applying a configuration lands the new ratio/enable and enters SETTLE
    // (enabled) or IDLE (stopped) with a fresh edge count.
    if (apply_s) begin
      state_s = apply_en_s ? ST_SETTLE : ST_IDLE;
    end else begin
      state_s = stay_s;
    end
    div_ratio_s = apply_s ? apply_ratio_s : div_ratio_r;
    clk_en_s    = apply_s ? apply_en_s    : clk_en_r;
    edge_cnt_s  = apply_s ? '0            : edge_cnt_c;
`ifdef CLKDIV_CTRL_PERIOD_CHK_EN
    per_cnt_s   = apply_s ? '0   : per_cnt_c;
    per_on_s    = apply_s ? 1'b0 : per_on_c;
    miss_cnt_s  = apply_s ? 4'd0 : miss_cnt_c;
`endif
    ready_s = (state_s == ST_IDLE);
    busy_s  = (state_s != ST_IDLE);
  end

  // State, configuration and output registers.
  always_ff @(posedge I_ref_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_r     <= ST_IDLE;
      div_d_r     <= 1'b0;
      cap_ratio_r <= DIV_W'(RESET_RATIO);
      cap_en_r    <= 1'b0;
      div_ratio_r <= DIV_W'(RESET_RATIO);
      clk_en_r    <= 1'b0;
      locked_r    <= 1'b0;
      err_r       <= 1'b0;
      timeout_r   <= 1'b0;
      ready_r     <= 1'b1;
      busy_r      <= 1'b0;
      wait_cnt_r  <= '0;
      edge_cnt_r  <= '0;
    end else begin
      state_r     <= state_s;
      div_d_r     <= I_div_clk;
      cap_ratio_r <= cap_ratio_s;
      cap_en_r    <= cap_en_s;
      div_ratio_r <= div_ratio_s;
      clk_en_r    <= clk_en_s;
      locked_r    <= locked_s;
      err_r       <= err_s;
      timeout_r   <= timeout_s;
      ready_r     <= ready_s;
      busy_r      <= busy_s;
      wait_cnt_r  <= wait_cnt_s;
      edge_cnt_r  <= edge_cnt_s;
    end
  end

`ifdef CLKDIV_CTRL_PERIOD_CHK_EN
  // Period measurement registers.
  always_ff @(posedge I_ref_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      per_cnt_r  <= '0;
      per_on_r   <= 1'b0;
      miss_cnt_r <= 4'd0;
    end else begin
      per_cnt_r  <= per_cnt_s;
      per_on_r   <= per_on_s;
      miss_cnt_r <= miss_cnt_s;
    end
  end
`endif

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Self-checking bench for clkdiv_ctrl. A behavioural divider drives I_div_clk;
// expected outcomes come from per-request event timing of that divider.
module tb_clkdiv_ctrl;
  localparam int DIV_W  = 32;
  localparam int MAX_R  = 64;
  localparam int LOCK   = 4;
  localparam int TMO    = 2*MAX_R + 4;
  localparam int LOCK_BOUND = 2*LOCK*MAX_R + 40;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [DIV_W-1:0] req_ratio;
  logic             req_en;
  logic             div_clk = 1'b0;
  logic [DIV_W-1:0] div_ratio;
  logic             clk_en;
  logic             busy;
  logic             locked;
  logic             err;
  logic             timeout;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state: last applied configuration and lock
  logic [DIV_W-1:0] m_ratio;
  logic             m_en;
  logic             m_locked;

  // behavioural divider controls and toggle flags
  logic freeze   = 1'b0;
  logic bad_mode = 1'b0;
  logic rose     = 1'b0;
  logic fell     = 1'b0;
  int   dcnt     = 0;
  int   lim;

  clkdiv_ctrl #(
    .DIV_W(DIV_W), .MAX_RATIO(MAX_R), .RESET_RATIO(2), .LOCK_EDGES(LOCK)
  ) dut (
    .I_ref_clk  (clk),
    .I_rst_n    (rst_n),
    .I_req_valid(req_valid),
    .O_req_ready(req_ready),
    .I_req_ratio(req_ratio),
    .I_req_en   (req_en),
    .I_div_clk  (div_clk),
    .O_div_ratio(div_ratio),
    .O_clk_en   (clk_en),
    .O_busy     (busy),
    .O_locked   (locked),
    .O_err      (err),
    .O_timeout  (timeout)
  );

  always #5 clk = ~clk;

  // divider: each half period lasts 'ratio' reference cycles
  always @(posedge clk) begin
    rose <= 1'b0;
    fell <= 1'b0;
    lim = (bad_mode && div_clk) ? 2 : int'(div_ratio) - 1;
    if (freeze) begin
      dcnt <= dcnt;
    end else if (!clk_en) begin
      dcnt    <= 0;
      div_clk <= 1'b0;
    end else if (dcnt >= lim) begin
      dcnt    <= 0;
      div_clk <= ~div_clk;
      rose    <= ~div_clk;
      fell    <= div_clk;
    end else begin
      dcnt <= dcnt + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // glitch check: every half period equals the ratio in force at its start or end
  int               hp_len = 0;
  logic             hp_valid = 1'b0;
  logic             last_div = 1'b0;
  logic [DIV_W-1:0] hp_r0 = '0;
  always @(negedge clk) begin
    if (!rst_n || !clk_en || freeze || bad_mode) begin
      hp_valid = 1'b0;
      hp_len   = 0;
      last_div = div_clk;
    end else if (div_clk != last_div) begin
      if (hp_valid)
        check_val("half_period", hp_len, (hp_len == int'(hp_r0)) ? hp_r0 : div_ratio);
      hp_valid = 1'b1;
      hp_len   = 1;
      hp_r0    = div_ratio;
      last_div = div_clk;
    end else begin
      hp_len++;
    end
  end

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_ratio"},   div_ratio, 2);
    check_val({tag, "_clk_en"},  clk_en,    0);
    check_val({tag, "_ready"},   req_ready, 1);
    check_val({tag, "_busy"},    busy,      0);
    check_val({tag, "_locked"},  locked,    0);
    check_val({tag, "_err"},     err,       0);
    check_val({tag, "_timeout"}, timeout,   0);
  endtask

  // one request through the handshake, with expectations from the model
  task automatic do_req(input logic [DIV_W-1:0] ratio, input logic en, input logic hold);
    int   j;
    int   rises;
    logic pf;
    logic bad;
    logic got;
    j = 0;
    while (!req_ready && j < LOCK_BOUND) begin
      tick;
      j++;
    end
    check_val("ready_before_req", req_ready, 1);
    freeze    = hold;
    req_valid = 1'b1;
    req_ratio = ratio;
    req_en    = en;
    tick;                                   // accept edge
    req_valid = 1'b0;
    bad = en && ((ratio < 2) || (ratio > MAX_R));
    if (bad) begin
      check_val("rej_err",    err,       1);
      check_val("rej_ratio",  div_ratio, m_ratio);
      check_val("rej_en",     clk_en,    m_en);
      check_val("rej_locked", locked,    m_locked);
      check_val("rej_ready",  req_ready, 1);
      tick;
      check_val("rej_err_pulse", err, 0);
      freeze = 1'b0;
      return;
    end
    check_val("acc_lock_drop", locked, 0);
    m_locked = 1'b0;
    if (!m_en) begin
      check_val("imm_ratio",   div_ratio, ratio);
      check_val("imm_en",      clk_en,    en);
      check_val("imm_timeout", timeout,   0);
    end else begin
      pf = fell;
      for (j = 1; j <= TMO; j++) begin
        tick;
        if (pf || j == TMO) begin
          check_val("wait_apply_ratio", div_ratio, ratio);
          check_val("wait_apply_en",    clk_en,    en);
          check_val("wait_timeout",     timeout,   !pf);
          break;
        end
        check_val("wait_hold_ratio", div_ratio, m_ratio);
        check_val("wait_busy",       busy,      1);
        pf = fell;
      end
    end
    m_ratio = ratio;
    m_en    = en;
    freeze  = 1'b0;
    if (!en) begin
      check_val("off_ready",  req_ready, 1);
      check_val("off_busy",   busy,      0);
      check_val("off_locked", locked,    0);
      return;
    end
    rises = rose ? 1 : 0;
    got   = 1'b0;
    for (j = 0; j < LOCK_BOUND; j++) begin
      tick;
      if (rises == LOCK) begin
        check_val("lock_set",   locked,    1);
        check_val("lock_ready", req_ready, 1);
        m_locked = 1'b1;
        got = 1'b1;
        break;
      end
      check_val("settle_unlocked", locked, 0);
      check_val("settle_busy",     busy,   1);
      if (rose) rises++;
    end
    if (!got) check_val("lock_seen", 0, 1);
  endtask

  initial begin
    logic [DIV_W-1:0] r;
    logic             e;
    logic             h;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_ratio = '0;
    req_en    = 1'b0;
    m_ratio   = 32'd2;
    m_en      = 1'b0;
    m_locked  = 1'b0;
    repeat (2) tick;
    check_reset_vals("rst");
    rst_n = 1'b1;
    tick;
    check_reset_vals("post_rst");

    // directed scenarios
    do_req(32'd4, 1'b1, 1'b0);              // from stopped: immediate apply
    do_req(32'd3, 1'b1, 1'b0);              // running: waits for a fall
    do_req(32'd1, 1'b1, 1'b0);              // rejected: too small
    do_req(MAX_R + 1, 1'b1, 1'b0);          // rejected: too large
    do_req(32'd6, 1'b1, 1'b0);
    do_req(32'd6, 1'b1, 1'b0);              // same config still applied
    do_req(32'd0, 1'b0, 1'b0);              // disable, ratio not range-checked
    do_req(MAX_R, 1'b1, 1'b0);              // largest legal ratio
    do_req(32'd5, 1'b1, 1'b1);              // divided clock frozen: timeout
    do_req(32'd2, 1'b1, 1'b0);              // smallest legal ratio

    // randomized requests
    repeat (30) begin
      case ($urandom_range(0, 5))
        0:       r = 32'($urandom_range(0, 1));
        1:       r = 32'($urandom_range(MAX_R + 1, MAX_R + 40));
        default: r = 32'($urandom_range(2, 10));
      endcase
      e = ($urandom_range(0, 4) != 0);
      h = m_en && ($urandom_range(0, 5) == 0);
      do_req(r, e, h);
    end

    // reset while waiting for an edge
    do_req(32'd8, 1'b1, 1'b0);
    freeze    = 1'b1;
    req_valid = 1'b1;
    req_ratio = 32'd3;
    req_en    = 1'b1;
    tick;
    req_valid = 1'b0;
    repeat (5) tick;
    check_val("midwait_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midwait_rst");
    @(negedge clk);
    freeze = 1'b0;
    rst_n  = 1'b1;
    m_ratio  = 32'd2;
    m_en     = 1'b0;
    m_locked = 1'b0;
    tick;
    do_req(32'd3, 1'b1, 1'b0);

`ifdef CLKDIV_CTRL_PERIOD_CHK_EN
    begin
      logic err_seen;
      logic lock_seen;
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      bad_mode  = 1'b1;                     // 3 high + 4 low = 7-cycle period
      req_valid = 1'b1;
      req_ratio = 32'd4;
      req_en    = 1'b1;
      tick;
      req_valid = 1'b0;
      err_seen  = 1'b0;
      lock_seen = 1'b0;
      repeat (70) begin
        tick;
        if (err)    err_seen  = 1'b1;
        if (locked) lock_seen = 1'b1;
      end
      check_val("per_err_seen", err_seen,  1);
      check_val("per_no_lock",  lock_seen, 0);
      bad_mode = 1'b0;
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
